bus_hold: RTL and testbench
===========================

BUS_HOLD -- requirements
Module: bus_hold

Interface
REQ-001 SHALL have parameter N, default 2: number of bus drivers, N >= 1.
REQ-002 SHALL have parameter W, default 8: bus width in bits, W >= 1.
REQ-003 SHALL have parameter DECAY, default 4: undriven cycles for which the bus retains charge, DECAY >= 1.
REQ-004 SHALL have parameter FLOAT_VAL, default all ones (W bits): value of a fully decayed bus.
REQ-005 SHALL have parameter CW, default 8: width of the contention counter.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port driver_values, input, [N-1:0][W-1:0]: per-driver data.
REQ-009 SHALL have port driver_enables, input, N bits: per-driver enable.
REQ-010 SHALL have port pull_down_enables, input, W bits: per-bit forced-low.
REQ-011 SHALL have port precharge, input, 1 bit: charges the undriven bus to all ones.
REQ-012 SHALL have port clear_contention, input, 1 bit: clears the contention status.
REQ-013 SHALL have port value, output, W bits: resolved bus value.
REQ-014 SHALL have port floating, output, 1 bit: bus is undriven and has fully decayed.
REQ-015 SHALL have port contention, output, 1 bit: sticky contention flag.
REQ-016 SHALL have port contention_count, output, CW bits: saturating count of contention cycles.

Function
REQ-017 driven = OR of driver_enables.
REQ-018 drv_and = bitwise AND of driver_values[j] over all enabled j; this is wired-AND (NMOS: low wins).
REQ-019 Source select, combinational, same cycle: if driven then drv_and; else if precharge then all ones; else if decay_cnt < DECAY then hold_q; else FLOAT_VAL.
REQ-020 value = selected source & ~pull_down_enables; pull-downs override every source, including precharge.
REQ-021 hold_q (W-bit register) loads value, post-pulldown, on every edge where driven or precharge is 1; otherwise it keeps its value.
REQ-022 decay_cnt (register) loads 0 on every edge where driven or precharge is 1; otherwise it increments, saturating at DECAY.
REQ-023 floating = !driven & !precharge & (decay_cnt == DECAY), combinational.
REQ-024 Contention event in a cycle = at least 2 drivers enabled and (OR of enabled values) != (AND of enabled values).
  - Identical values on several enabled drivers are not contention.
REQ-025 On an edge with a contention event: contention sets to 1; contention_count increments, saturating at 2^CW-1.
REQ-026 On an edge with clear_contention = 1 and no event: contention becomes 0 and contention_count becomes 0.
REQ-027 On an edge with clear_contention = 1 and an event in the same cycle: the event wins; contention = 1 and contention_count = 1.
REQ-028 value and floating have zero latency from the inputs; contention and contention_count have one cycle of latency.
REQ-029 The decay window: with the bus undriven and no precharge from cycle k onward, hold_q is presented for cycles k..k+DECAY-1 and FLOAT_VAL from cycle k+DECAY onward.
REQ-030 N = 1 SHALL never report contention.

Reset
REQ-031 With rst_n = 0 at an edge, the following SHALL hold after that edge, with all other inputs ignored:
  - hold_q = FLOAT_VAL
  - decay_cnt = DECAY
  - contention = 0
  - contention_count = 0
REQ-032 Consequently, after reset with no driver and no precharge: value = FLOAT_VAL & ~pull_down_enables and floating = 1.
REQ-033 Reset asserted mid-decay or mid-contention SHALL abandon that state without producing any further increment.
REQ-034 The combinational value path SHALL remain live during reset: driven inputs still appear on value.

Verification (N=2, W=8, DECAY=4, CW=8, FLOAT_VAL=FF)
REQ-035 Reset scenario: after reset, enables=00, pd=00 -> value=FF, floating=1, contention=0, count=00.
REQ-036 Decay scenario:
  - Stimulus: driver0=A5 enabled 1 cycle, then enables=00 and precharge=0 for 6 cycles.
  - Response: value=A5 in the driven cycle and in the 4 following cycles; then FF with floating=1.
REQ-037 Precharge and pull-down scenario: precharge=1, pd=0F, no drivers -> value=F0; after precharge drops, value=F0 is held for 4 cycles.
REQ-038 Contention scenario:
  - Stimulus: drivers 3C and 0F both enabled for 3 cycles.
  - Response: value=0C each cycle; after those cycles contention=1 and count=03.
  - Check: drivers 55 and 55 both enabled -> no increment.
REQ-039 Clear scenario:
  - Stimulus: clear_contention=1 together with a contention event.
  - Response: count=01, contention=1; a following clear with no event gives count=00, contention=0.
REQ-040 Saturation and mid-operation reset scenario:
  - 300 contention cycles -> count=FF.
  - rst_n=0 during decay -> floating=1 on the next cycle.

Source files
------------

// File: rtl/bus_hold_if.sv
// Bus-side signal bundle for bus_hold: driver inputs, bus controls and the
// resolved bus/contention status.
interface bus_hold_if #(
    parameter int N  = 2,
    parameter int W  = 8,
    parameter int CW = 8
);
    logic [N-1:0][W-1:0] driver_values;
    logic [N-1:0]        driver_enables;
    logic [W-1:0]        pull_down_enables;
    logic                precharge;
    logic                clear_contention;
    logic [W-1:0]        value;
    logic                floating;
    logic                contention;
    logic [CW-1:0]       contention_count;

    modport master (
        output driver_values,
        output driver_enables,
        output pull_down_enables,
        output precharge,
        output clear_contention,
        input  value,
        input  floating,
        input  contention,
        input  contention_count
    );

    modport slave (
        input  driver_values,
        input  driver_enables,
        input  pull_down_enables,
        input  precharge,
        input  clear_contention,
        output value,
        output floating,
        output contention,
        output contention_count
    );
endinterface

// File: rtl/bus_hold.sv
// Wired-AND shared bus with charge retention, precharge, per-bit pull-downs
// and a sticky, saturating contention monitor.
module bus_hold #(
    parameter int             N         = 2,
    parameter int             W         = 8,
    parameter int             DECAY     = 4,
    parameter logic [W-1:0]   FLOAT_VAL = '1,
    parameter int             CW        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    bus_hold_if.slave   bus
);
    localparam int              DC_W    = $clog2(DECAY + 1);
    localparam logic [DC_W-1:0] DECAY_C = DC_W'(DECAY);
    localparam logic [CW-1:0]   CNT_MAX = '1;

    logic          driven;
    logic          load;
    logic          multi_en;
    logic          cont_event;
    logic [W-1:0]  drv_and;
    logic [W-1:0]  drv_or;
    logic [W-1:0]  src;

    logic [W-1:0]    hold_q;
    logic [DC_W-1:0] decay_cnt;
    logic            cont_q;
    logic [CW-1:0]   cnt_q;

    // Low wins: AND across enabled drivers. The OR is kept only to detect
    // enabled drivers that disagree.
    always_comb begin
        drv_and = '1;
        drv_or  = '0;
        for (int j = 0; j < N; j++) begin
            if (bus.driver_enables[j]) begin
                drv_and = drv_and & bus.driver_values[j];
                drv_or  = drv_or  | bus.driver_values[j];
            end
        end
    end

    assign driven     = |bus.driver_enables;
    assign load       = driven | bus.precharge;
    // More than one enable bit set: clearing the lowest set bit leaves something.
    assign multi_en   = (bus.driver_enables & (bus.driver_enables - N'(1))) != '0;
    assign cont_event = multi_en && (drv_or != drv_and);

    always_comb begin
        src = FLOAT_VAL;
        if (driven)
            src = drv_and;
        else if (bus.precharge)
            src = '1;
        else if (decay_cnt < DECAY_C)
            src = hold_q;
    end

    assign bus.value            = src & ~bus.pull_down_enables;
    assign bus.floating         = !driven && !bus.precharge && (decay_cnt == DECAY_C);
    assign bus.contention       = cont_q;
    assign bus.contention_count = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q    <= FLOAT_VAL;
            decay_cnt <= DECAY_C;
        end else if (load) begin
            hold_q    <= bus.value;
            decay_cnt <= '0;
        end else if (decay_cnt != DECAY_C) begin
            decay_cnt <= decay_cnt + DC_W'(1);
        end
    end

    // A contention event in the same cycle as a clear takes priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cont_q <= 1'b0;
            cnt_q  <= '0;
        end else if (cont_event) begin
            cont_q <= 1'b1;
            if (bus.clear_contention)
                cnt_q <= CW'(1);
            else if (cnt_q != CNT_MAX)
                cnt_q <= cnt_q + CW'(1);
        end else if (bus.clear_contention) begin
            cont_q <= 1'b0;
            cnt_q  <= '0;
        end
    end
endmodule

// File: tb/tb_bus_hold.sv
// Self-checking bench for bus_hold: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model.
module tb_bus_hold;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    bus_hold_if #(.N(2), .W(8), .CW(8)) bus ();
    bus_hold_if #(.N(1), .W(8), .CW(8)) bus1 ();

    bus_hold #(.N(2), .W(8), .DECAY(4), .FLOAT_VAL(8'hFF), .CW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    bus_hold #(.N(1), .W(8), .DECAY(4), .FLOAT_VAL(8'hFF), .CW(8)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    assign bus1.driver_values     = bus.driver_values[0];
    assign bus1.driver_enables    = bus.driver_enables[0];
    assign bus1.pull_down_enables = bus.pull_down_enables;
    assign bus1.precharge         = bus.precharge;
    assign bus1.clear_contention  = bus.clear_contention;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Behavioural model: last stored bus level, cycles since the bus was
    // last driven or precharged, and contention status.
    logic [7:0] m_hold;
    int         m_idle;
    bit         m_cont;
    int         m_cnt;

    function automatic logic [7:0] m_value();
        logic [7:0] acc;
        bit any;
        any = 0;
        acc = 8'hFF;
        for (int j = 0; j < 2; j++)
            if (bus.driver_enables[j]) begin
                any = 1;
                acc = acc & bus.driver_values[j];
            end
        if (!any) begin
            if (bus.precharge)   acc = 8'hFF;
            else if (m_idle < 4) acc = m_hold;
            else                 acc = 8'hFF;
        end
        return acc & ~bus.pull_down_enables;
    endfunction

    function automatic bit m_floating();
        return (bus.driver_enables == 2'b00) && !bus.precharge && (m_idle >= 4);
    endfunction

    function automatic bit m_event();
        int ne;
        bit diff;
        logic [7:0] first;
        ne = 0;
        diff = 0;
        first = 8'h00;
        for (int j = 0; j < 2; j++)
            if (bus.driver_enables[j]) begin
                if (ne == 0) first = bus.driver_values[j];
                else if (bus.driver_values[j] != first) diff = 1;
                ne++;
            end
        return (ne >= 2) && diff;
    endfunction

    task automatic model_edge();
        bit ev;
        logic [7:0] v;
        ev = m_event();
        v  = m_value();
        if (!rst_n) begin
            m_hold = 8'hFF;
            m_idle = 4;
            m_cont = 0;
            m_cnt  = 0;
        end else begin
            if (bus.driver_enables != 2'b00 || bus.precharge) begin
                m_hold = v;
                m_idle = 0;
            end else if (m_idle < 4) begin
                m_idle++;
            end
            if (ev) begin
                m_cont = 1;
                m_cnt  = bus.clear_contention ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
            end else if (bus.clear_contention) begin
                m_cont = 0;
                m_cnt  = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        bus.driver_values     = '0;
        bus.driver_enables    = '0;
        bus.pull_down_enables = '0;
        bus.precharge         = 1'b0;
        bus.clear_contention  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_total++; if (bus.value !== 8'hFF) $display("FAIL reset_value got=%h exp=%h", bus.value, 8'hFF); else n_pass++;
        n_total++; if (bus.floating !== 1'b1) $display("FAIL reset_floating got=%b exp=1", bus.floating); else n_pass++;
        n_total++; if (bus.contention !== 1'b0) $display("FAIL reset_contention got=%b exp=0", bus.contention); else n_pass++;
        n_total++; if (bus.contention_count !== 8'h00) $display("FAIL reset_count got=%h exp=00", bus.contention_count); else n_pass++;
        tick();
    endtask

    task automatic test_decay();
        logic [7:0] exp_v;
        do_reset();
        bus.driver_values[0] = 8'hA5;
        bus.driver_enables   = 2'b01;
        #1;
        n_total++; if (bus.value !== 8'hA5) $display("FAIL decay_driven got=%h exp=A5", bus.value); else n_pass++;
        tick();
        bus.driver_enables = 2'b00;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_v = (i < 4) ? 8'hA5 : 8'hFF;
            n_total++; if (bus.value !== exp_v) $display("FAIL decay_value cyc=%0d got=%h exp=%h", i, bus.value, exp_v); else n_pass++;
            n_total++; if (bus.floating !== (i >= 4)) $display("FAIL decay_floating cyc=%0d got=%b exp=%b", i, bus.floating, (i >= 4)); else n_pass++;
            tick();
        end
    endtask

    task automatic test_precharge_pulldown();
        logic [7:0] exp_v;
        do_reset();
        bus.precharge         = 1'b1;
        bus.pull_down_enables = 8'h0F;
        #1;
        n_total++; if (bus.value !== 8'hF0) $display("FAIL precharge_pd got=%h exp=F0", bus.value); else n_pass++;
        n_total++; if (bus.floating !== 1'b0) $display("FAIL precharge_floating got=%b exp=0", bus.floating); else n_pass++;
        tick();
        bus.precharge         = 1'b0;
        bus.pull_down_enables = 8'h00;
        for (int i = 0; i < 5; i++) begin
            #1;
            exp_v = (i < 4) ? 8'hF0 : 8'hFF;
            n_total++; if (bus.value !== exp_v) $display("FAIL precharge_hold cyc=%0d got=%h exp=%h", i, bus.value, exp_v); else n_pass++;
            tick();
        end
    endtask

    task automatic test_contention();
        do_reset();
        bus.driver_values[0] = 8'h3C;
        bus.driver_values[1] = 8'h0F;
        bus.driver_enables   = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++; if (bus.value !== 8'h0C) $display("FAIL contention_value cyc=%0d got=%h exp=0C", i, bus.value); else n_pass++;
            tick();
        end
        n_total++; if (bus.contention !== 1'b1) $display("FAIL contention_flag got=%b exp=1", bus.contention); else n_pass++;
        n_total++; if (bus.contention_count !== 8'h03) $display("FAIL contention_count got=%h exp=03", bus.contention_count); else n_pass++;
        bus.driver_values[0] = 8'h55;
        bus.driver_values[1] = 8'h55;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_total++; if (bus.value !== 8'h55) $display("FAIL agree_value got=%h exp=55", bus.value); else n_pass++;
            tick();
        end
        n_total++; if (bus.contention_count !== 8'h03) $display("FAIL agree_no_increment got=%h exp=03", bus.contention_count); else n_pass++;
    endtask

    task automatic test_clear();
        bus.driver_values[0]  = 8'h3C;
        bus.driver_values[1]  = 8'h0F;
        bus.driver_enables    = 2'b11;
        bus.clear_contention  = 1'b1;
        tick();
        n_total++; if (bus.contention_count !== 8'h01) $display("FAIL clear_with_event_count got=%h exp=01", bus.contention_count); else n_pass++;
        n_total++; if (bus.contention !== 1'b1) $display("FAIL clear_with_event_flag got=%b exp=1", bus.contention); else n_pass++;
        bus.driver_enables = 2'b00;
        tick();
        n_total++; if (bus.contention_count !== 8'h00) $display("FAIL clear_count got=%h exp=00", bus.contention_count); else n_pass++;
        n_total++; if (bus.contention !== 1'b0) $display("FAIL clear_flag got=%b exp=0", bus.contention); else n_pass++;
        bus.clear_contention = 1'b0;
    endtask

    task automatic test_saturation();
        logic [7:0] v0;
        do_reset();
        bus.driver_enables = 2'b11;
        for (int i = 0; i < 300; i++) begin
            v0 = 8'($urandom);
            bus.driver_values[0] = v0;
            bus.driver_values[1] = v0 ^ 8'($urandom_range(1, 255));
            tick();
            if (i == 254) begin
                n_total++; if (bus.contention_count !== 8'hFF) $display("FAIL saturation_reach got=%h exp=FF", bus.contention_count); else n_pass++;
            end
        end
        n_total++; if (bus.contention_count !== 8'hFF) $display("FAIL saturation_hold got=%h exp=FF", bus.contention_count); else n_pass++;
        n_total++; if (bus.contention !== 1'b1) $display("FAIL saturation_flag got=%b exp=1", bus.contention); else n_pass++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.driver_values[0] = 8'hA5;
        bus.driver_enables   = 2'b01;
        tick();
        bus.driver_enables = 2'b00;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        n_total++; if (bus.floating !== 1'b1) $display("FAIL mid_decay_reset_floating got=%b exp=1", bus.floating); else n_pass++;
        n_total++; if (bus.value !== 8'hFF) $display("FAIL mid_decay_reset_value got=%h exp=FF", bus.value); else n_pass++;
        bus.driver_values[0] = 8'h3C;
        bus.driver_values[1] = 8'h0F;
        bus.driver_enables   = 2'b11;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_total++; if (bus.value !== 8'h0C) $display("FAIL reset_live_value got=%h exp=0C", bus.value); else n_pass++;
        tick();
        n_total++; if (bus.contention_count !== 8'h00) $display("FAIL mid_cont_reset_count got=%h exp=00", bus.contention_count); else n_pass++;
        n_total++; if (bus.contention !== 1'b0) $display("FAIL mid_cont_reset_flag got=%b exp=0", bus.contention); else n_pass++;
        rst_n = 1'b1;
        bus.driver_enables = 2'b00;
        tick();
        n_total++; if (bus.contention_count !== 8'h00) $display("FAIL post_reset_count got=%h exp=00", bus.contention_count); else n_pass++;
    endtask

    task automatic test_random();
        int r;
        logic [7:0] exp_v;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            r = $urandom_range(0, 9);
            if (r < 4)      bus.driver_enables = 2'b00;
            else if (r < 7) bus.driver_enables = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            else            bus.driver_enables = 2'b11;
            bus.driver_values[0] = 8'($urandom);
            bus.driver_values[1] = ($urandom_range(0, 3) == 0) ? bus.driver_values[0] : 8'($urandom);
            bus.precharge         = ($urandom_range(0, 7) == 0);
            bus.pull_down_enables = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
            bus.clear_contention  = ($urandom_range(0, 15) == 0);
            #1;
            exp_v = m_value();
            n_total++; if (bus.value !== exp_v) $display("FAIL rand_value cyc=%0d got=%h exp=%h", i, bus.value, exp_v); else n_pass++;
            n_total++; if (bus.floating !== m_floating()) $display("FAIL rand_floating cyc=%0d got=%b exp=%b", i, bus.floating, m_floating()); else n_pass++;
            tick();
            n_total++; if (bus.contention !== m_cont) $display("FAIL rand_contention cyc=%0d got=%b exp=%b", i, bus.contention, m_cont); else n_pass++;
            n_total++; if (bus.contention_count !== 8'(m_cnt)) $display("FAIL rand_count cyc=%0d got=%h exp=%h", i, bus.contention_count, 8'(m_cnt)); else n_pass++;
            n_total++; if (bus1.contention !== 1'b0) $display("FAIL single_driver_contention cyc=%0d got=%b exp=0", i, bus1.contention); else n_pass++;
        end
        rst_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_hold  = 8'hFF;
        m_idle  = 4;
        m_cont  = 0;
        m_cnt   = 0;
        rst_n   = 1'b0;
        idle_inputs();
        test_reset();
        test_decay();
        test_precharge_pulldown();
        test_contention();
        test_clear();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
